oled_spi_receiver: RTL
======================

OLED_SPI_RECEIVER -- requirements
Module: oled_spi_receiver

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- NUM_COL, 96, display columns.
- NUM_ROW, 64, display rows.
- WIDTH, 8, bits per SPI byte and per pixel.
REQ-002 Ports, one per line (name, direction, width, meaning):
- i_CLK, in, 1, system clock; one clock; all logic on its rising edge.
- i_RST_N, in, 1, reset; synchronous and active-low.
- i_SCK, in, 1, SPI clock from the OLED master.
- i_MOSI, in, 1, serial data, MSB first.
- i_CS, in, 1, chip select, active-low.
- i_DC, in, 1, 0 = command byte, 1 = data byte.
- o_BYTE_VALID, out, 1, one-cycle strobe: received byte available.
- o_BYTE, out, WIDTH, received byte.
- o_BYTE_DC, out, 1, DC level captured with the byte.
- o_PIX_WE, out, 1, one-cycle pixel write strobe.
- o_PIX_COL, out, 7, pixel column.
- o_PIX_ROW, out, 6, pixel row.
- o_PIX_DATA, out, WIDTH, pixel color.
- o_DISPLAY_ON, out, 1, display-on state.
- o_REMAP, out, 8, last 0xA0 parameter.
- o_CMD_ERR, out, 1, one-cycle strobe: unknown command or bad parameter.
- o_FRAME_ERR, out, 1, one-cycle strobe: CS released mid-byte.
- i_RD_COL, in, 7, framebuffer read column.
- i_RD_ROW, in, 6, framebuffer read row.
- o_RD_DATA, out, WIDTH, framebuffer read data.

Function
REQ-003 i_SCK, i_MOSI, i_CS and i_DC each pass through two synchronizer flops; an SCK rising edge is detected as sync=1 and previous=0.
REQ-004 i_CLK SHALL be at least 4x the SCK frequency; slower ratios are unsupported.
REQ-005 While synced CS=1: bit counter holds 0 and SCK edges are ignored.
REQ-006 On each detected SCK rise with CS=0: shift MOSI into the shift register, MSB first, and increment the bit counter.
REQ-007 On the 8th bit: the byte is complete.
- The cycle after completion: o_BYTE_VALID=1 with o_BYTE and o_BYTE_DC (DC sampled on the 8th edge).
- Bit counter returns to 0.
REQ-008 CS rising with bit counter in 1..7: o_FRAME_ERR pulses and the partial byte is discarded; decoder state is unaffected.
REQ-009 Decoder FSM states: CMD, COL_S, COL_E, ROW_S, ROW_E, REMAP_P. It advances only on o_BYTE_VALID; it is preserved across CS deassertion.
REQ-010 Command bytes (DC=0) received in CMD:
- 0x15 -> COL_S; 0x75 -> ROW_S; 0xA0 -> REMAP_P.
- 0xAF sets o_DISPLAY_ON=1; 0xAE clears it.
- Any other value pulses o_CMD_ERR and stays in CMD.
REQ-011 Parameter bytes arrive with DC=0.
- COL_S -> COL_E -> CMD: stages column start, then end.
- ROW_S -> ROW_E -> CMD: stages row start, then end.
- REMAP_P: loads o_REMAP, then -> CMD.
REQ-012 The window commits only at COL_E/ROW_E, and only if start<=end and end<NUM_COL (resp. NUM_ROW). Otherwise o_CMD_ERR pulses and the old window is kept. On commit, the write pointer moves to (start column, start row) of the new window.
REQ-013 A data byte (DC=1) in any state:
- If in a parameter state: abort the sequence without commit, return to CMD, pulse o_CMD_ERR.
- In all cases, perform a pixel write.
REQ-014 Pixel write: the cycle after o_BYTE_VALID, o_PIX_WE=1 with the current pointer and o_PIX_DATA = byte. Then the pointer advances:
- column++.
- At col_end: column = col_start and row++.
- At row_end as well: row = row_start (wraps to window origin).
REQ-015 Simultaneous CS rise and 8th SCK edge in one cycle: the byte completes; no frame error.

Reset
REQ-016 When i_RST_N=0 at a clock edge:
- Strobes = 0; o_BYTE = 0; o_BYTE_DC = 0; o_PIX_* = 0.
- o_DISPLAY_ON = 0; o_REMAP = 0x00.
- FSM = CMD; window = cols 0..NUM_COL-1, rows 0..NUM_ROW-1; pointer = (0,0).
- Bit counter = 0; synchronizers = idle (SCK=0, CS=1).
REQ-017 Reset mid-byte or mid-command discards all partial state. Framebuffer contents are not cleared.

Configuration
REQ-018 With OLED_RX_FRAMEBUFFER_EN defined:
- A NUM_COL*NUM_ROW x WIDTH memory is written by o_PIX_WE.
- Read: o_RD_DATA valid one cycle after i_RD_COL/i_RD_ROW.
REQ-019 Without OLED_RX_FRAMEBUFFER_EN: no memory is instantiated and o_RD_DATA = 0 constantly.

Structure
REQ-020 Shared package holds: command opcodes (0x15, 0x75, 0xA0, 0xAE, 0xAF), decoder state encoding, NUM_COL/NUM_ROW defaults.
REQ-021 One sub-module, spi_byte_receiver, owns REQ-003..REQ-008 and REQ-015. The decoder, pointer and framebuffer live in the top module.

Verification
REQ-022 Bytes 0xAF, 0xA0, 0x20 with DC=0 -> three o_BYTE_VALID strobes; o_DISPLAY_ON=1; o_REMAP=0x20.
REQ-023 Commands 0x15,0x08,0x0F, 0x75,0x10,0x17, then 64 data bytes -> writes at (8,16)..(15,16), (8,17)..(15,23); a 65th byte writes at (8,16).
REQ-024 Command 0x15,0x60,0x61 (end 97>95) -> o_CMD_ERR pulse; the next data byte writes at the prior pointer.
REQ-025 CS raised after 5 bits -> o_FRAME_ERR pulse and no o_BYTE_VALID; the next full byte 0xA5 is received correctly.
REQ-026 0x15 then a DC=1 byte 0xE0 -> o_CMD_ERR pulse; pixel 0xE0 written; FSM back in CMD.
REQ-027 Reset asserted after 0x75,0x04 -> window is full screen, pointer (0,0), o_DISPLAY_ON=0. With the framebuffer enabled, reading (8,16) after REQ-023 returns the first data byte.

Source files
------------

// File: rtl/oled_spi_receiver_pkg.sv
// Shared opcodes, decoder state encoding and geometry defaults for the OLED SPI receiver.
package oled_spi_receiver_pkg;

  localparam int unsigned NUM_COL_DEF = 96;
  localparam int unsigned NUM_ROW_DEF = 64;
  localparam int unsigned WIDTH_DEF   = 8;
  localparam int unsigned COL_W       = 7;
  localparam int unsigned ROW_W       = 6;

  localparam logic [7:0] OP_COL      = 8'h15;
  localparam logic [7:0] OP_ROW      = 8'h75;
  localparam logic [7:0] OP_REMAP    = 8'hA0;
  localparam logic [7:0] OP_DISP_OFF = 8'hAE;
  localparam logic [7:0] OP_DISP_ON  = 8'hAF;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_COL_S,
    ST_COL_E,
    ST_ROW_S,
    ST_ROW_E,
    ST_REMAP_P
  } dec_state_t;

endpackage

// File: rtl/oled_spi_receiver_spi_byte_receiver.sv
// Oversampled SPI slave: synchronizes SCK/MOSI/CS/DC, assembles MSB-first bytes,
// flags CS released mid-byte.
module spi_byte_receiver
  import oled_spi_receiver_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sck,
  input  logic             mosi,
  input  logic             cs,
  input  logic             dc,
  output logic             byte_valid,
  output logic [WIDTH-1:0] byte_data,
  output logic             byte_dc,
  output logic             frame_err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       sck_sync, cs_sync, mosi_sync, dc_sync;
  logic             sck_prev, cs_prev;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift;

  logic             sck_rise, cs_rise, take, last;
  logic [WIDTH-1:0] shift_next;

  // An edge coinciding with CS rising still counts so a just-finished byte completes.
  always_comb begin
    sck_rise   = sck_sync[1] & ~sck_prev;
    cs_rise    = cs_sync[1] & ~cs_prev;
    take       = sck_rise & ~(cs_sync[1] & cs_prev);
    last       = take & (bit_cnt == CNT_W'(WIDTH - 1));
    shift_next = {shift[WIDTH-2:0], mosi_sync[1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sync   <= 2'b00;
      cs_sync    <= 2'b11;
      mosi_sync  <= 2'b00;
      dc_sync    <= 2'b00;
      sck_prev   <= 1'b0;
      cs_prev    <= 1'b1;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sck_sync   <= {sck_sync[0], sck};
      cs_sync    <= {cs_sync[0], cs};
      mosi_sync  <= {mosi_sync[0], mosi};
      dc_sync    <= {dc_sync[0], dc};
      sck_prev   <= sck_sync[1];
      cs_prev    <= cs_sync[1];
      byte_valid <= last;
      frame_err  <= cs_rise & (bit_cnt != '0) & ~last;
      if (last) begin
        byte_data <= shift_next;
        byte_dc   <= dc_sync[1];
      end
      if (take) shift <= shift_next;
      if (last || (cs_sync[1] && !take)) bit_cnt <= '0;
      else if (take)                     bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/oled_spi_receiver.sv
// OLED controller front end: SPI byte receiver, command decoder, windowed pixel pointer.
// Optional framebuffer enabled by defining OLED_RX_FRAMEBUFFER_EN.
module oled_spi_receiver
  import oled_spi_receiver_pkg::*;
#(
  parameter int unsigned NUM_COL = NUM_COL_DEF,
  parameter int unsigned NUM_ROW = NUM_ROW_DEF,
  parameter int unsigned WIDTH   = WIDTH_DEF
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_SCK,
  input  logic             i_MOSI,
  input  logic             i_CS,
  input  logic             i_DC,
  output logic             o_BYTE_VALID,
  output logic [WIDTH-1:0] o_BYTE,
  output logic             o_BYTE_DC,
  output logic             o_PIX_WE,
  output logic [COL_W-1:0] o_PIX_COL,
  output logic [ROW_W-1:0] o_PIX_ROW,
  output logic [WIDTH-1:0] o_PIX_DATA,
  output logic             o_DISPLAY_ON,
  output logic [7:0]       o_REMAP,
  output logic             o_CMD_ERR,
  output logic             o_FRAME_ERR,
  input  logic [COL_W-1:0] i_RD_COL,
  input  logic [ROW_W-1:0] i_RD_ROW,
  output logic [WIDTH-1:0] o_RD_DATA
);

  dec_state_t       state;
  logic [WIDTH-1:0] stage;
  logic [COL_W-1:0] col_start, col_end, ptr_col;
  logic [ROW_W-1:0] row_start, row_end, ptr_row;

  spi_byte_receiver #(.WIDTH(WIDTH)) u_rx (
    .clk        (i_CLK),
    .rst_n      (i_RST_N),
    .sck        (i_SCK),
    .mosi       (i_MOSI),
    .cs         (i_CS),
    .dc         (i_DC),
    .byte_valid (o_BYTE_VALID),
    .byte_data  (o_BYTE),
    .byte_dc    (o_BYTE_DC),
    .frame_err  (o_FRAME_ERR)
  );

  // Decoder, window registers and write pointer; advances only on a received byte.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state        <= ST_CMD;
      stage        <= '0;
      col_start    <= '0;
      col_end      <= COL_W'(NUM_COL - 1);
      row_start    <= '0;
      row_end      <= ROW_W'(NUM_ROW - 1);
      ptr_col      <= '0;
      ptr_row      <= '0;
      o_PIX_WE     <= 1'b0;
      o_PIX_COL    <= '0;
      o_PIX_ROW    <= '0;
      o_PIX_DATA   <= '0;
      o_DISPLAY_ON <= 1'b0;
      o_REMAP      <= 8'h00;
      o_CMD_ERR    <= 1'b0;
    end else begin
      o_PIX_WE  <= 1'b0;
      o_CMD_ERR <= 1'b0;
      if (o_BYTE_VALID) begin
        if (o_BYTE_DC) begin
          // Data aborts any half-finished parameter sequence but is still written.
          if (state != ST_CMD) o_CMD_ERR <= 1'b1;
          state      <= ST_CMD;
          o_PIX_WE   <= 1'b1;
          o_PIX_COL  <= ptr_col;
          o_PIX_ROW  <= ptr_row;
          o_PIX_DATA <= o_BYTE;
          if (ptr_col == col_end) begin
            ptr_col <= col_start;
            ptr_row <= (ptr_row == row_end) ? row_start : ptr_row + ROW_W'(1);
          end else begin
            ptr_col <= ptr_col + COL_W'(1);
          end
        end else begin
          case (state)
            ST_CMD: begin
              case (o_BYTE)
                WIDTH'(OP_COL):      state <= ST_COL_S;
                WIDTH'(OP_ROW):      state <= ST_ROW_S;
                WIDTH'(OP_REMAP):    state <= ST_REMAP_P;
                WIDTH'(OP_DISP_ON):  o_DISPLAY_ON <= 1'b1;
                WIDTH'(OP_DISP_OFF): o_DISPLAY_ON <= 1'b0;
                default:             o_CMD_ERR <= 1'b1;
              endcase
            end
            ST_COL_S: begin
              stage <= o_BYTE;
              state <= ST_COL_E;
            end
            ST_COL_E: begin
              if (stage <= o_BYTE && 32'(o_BYTE) < NUM_COL) begin
                col_start <= COL_W'(stage);
                col_end   <= COL_W'(o_BYTE);
                ptr_col   <= COL_W'(stage);
                ptr_row   <= row_start;
              end else begin
                o_CMD_ERR <= 1'b1;
              end
              state <= ST_CMD;
            end
            ST_ROW_S: begin
              stage <= o_BYTE;
              state <= ST_ROW_E;
            end
            ST_ROW_E: begin
              if (stage <= o_BYTE && 32'(o_BYTE) < NUM_ROW) begin
                row_start <= ROW_W'(stage);
                row_end   <= ROW_W'(o_BYTE);
                ptr_col   <= col_start;
                ptr_row   <= ROW_W'(stage);
              end else begin
                o_CMD_ERR <= 1'b1;
              end
              state <= ST_CMD;
            end
            ST_REMAP_P: begin
              o_REMAP <= 8'(o_BYTE);
              state   <= ST_CMD;
            end
            default: state <= ST_CMD;
          endcase
        end
      end
    end
  end

`ifdef OLED_RX_FRAMEBUFFER_EN
  localparam int unsigned DEPTH = NUM_COL * NUM_ROW;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [WIDTH-1:0] fb_mem [DEPTH];
  logic [AW-1:0]    wr_addr, rd_addr;

  always_comb begin
    wr_addr = AW'(32'(o_PIX_ROW) * NUM_COL + 32'(o_PIX_COL));
    rd_addr = AW'(32'(i_RD_ROW) * NUM_COL + 32'(i_RD_COL));
  end

  // Memory contents survive reset; only the read register clears.
  always_ff @(posedge i_CLK) begin
    if (o_PIX_WE) fb_mem[wr_addr] <= o_PIX_DATA;
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) o_RD_DATA <= '0;
    else          o_RD_DATA <= fb_mem[rd_addr];
  end
`else
  logic unused_rd;
  assign unused_rd = ^{i_RD_COL, i_RD_ROW};
  assign o_RD_DATA = '0;
`endif

endmodule
